// File: rtl/toy_alu_issue_arb_pkg.sv
// rtl/toy_alu_issue_arb_pkg.sv - shared types and opcode decode for the ALU issue arbiter
package toy_alu_issue_arb_pkg;

    localparam int INST_WIDTH     = 32;
    localparam int INST_IDX_WIDTH = 4;
    localparam int REG_WIDTH      = 32;
    localparam int ADDR_WIDTH     = 32;

    // Opcode occupies the low seven bits of the instruction word.
    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;

    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [INST_WIDTH-1:0]     pld;
        logic [INST_IDX_WIDTH-1:0] idx;
        logic [4:0]                rd_idx;
        logic                      rd_en;
        logic [REG_WIDTH-1:0]      rs1;
        logic [REG_WIDTH-1:0]      rs2;
        logic [ADDR_WIDTH-1:0]     pc;
        logic [31:0]               imm;
    } toy_alu_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_FENCE = 2'd2
    } toy_arb_state_e;

    function automatic logic is_ctrl_flow(input logic [OPC_W-1:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/toy_alu_issue_arb_rr_picker.sv
// rtl/toy_alu_issue_arb_rr_picker.sv - combinational round-robin one-hot picker
module toy_alu_issue_arb_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] vld,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    always_comb begin : pick
        logic             found;
        logic [PTR_W:0]   cand_ext;
        logic [PTR_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand_ext  = '0;
        cand      = '0;
        // Walk ptr, ptr+1, ... modulo NUM_REQ; the extra bit absorbs the wrap.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_ext = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand_ext >= (PTR_W+1)'(NUM_REQ)) begin
                cand_ext = cand_ext - (PTR_W+1)'(NUM_REQ);
            end
            cand = cand_ext[PTR_W-1:0];
            if (!found && vld[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/toy_alu_issue_arb.sv
// rtl/toy_alu_issue_arb.sv - round-robin issue arbiter feeding a one-entry ALU issue register
module toy_alu_issue_arb
    import toy_alu_issue_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_vld,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  toy_alu_req_t [NUM_REQ-1:0] req_bundle,
    input  logic                       flush,
    output logic                       alu_vld,
    input  logic                       alu_rdy,
    output toy_alu_req_t               alu_bundle,
    input  logic                       alu_pc_release_en,
    output logic                       fence_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    toy_arb_state_e   state;
    toy_arb_state_e   state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0] grant_idx;
    logic             fence;
    logic             load_ok;
    logic             accept;
    logic             consumed;
    logic             release_hit;
    logic             sel_ctrl;
    toy_alu_req_t     sel_bundle;

    toy_alu_issue_arb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .vld       (req_vld),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // rst_n gating keeps req_rdy low for the whole reset window, not just after the edge.
    assign load_ok     = rst_n & (~alu_vld | alu_rdy) & ~fence & ~flush;
    assign req_rdy     = grant & {NUM_REQ{load_ok}};
    assign accept      = |(req_vld & req_rdy);
    assign consumed    = alu_vld & alu_rdy;
    assign release_hit = (state == ARB_FENCE) & alu_pc_release_en & consumed;
    assign sel_bundle  = req_bundle[grant_idx];
    assign sel_ctrl    = is_ctrl_flow(sel_bundle.pld[OPC_LSB +: OPC_W]);
    assign ptr_nxt     = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) state_nxt = sel_ctrl ? ARB_FENCE : ARB_ISSUE;
                end
                ARB_ISSUE: begin
                    if (accept)        state_nxt = sel_ctrl ? ARB_FENCE : ARB_ISSUE;
                    else if (consumed) state_nxt = ARB_IDLE;
                end
                ARB_FENCE: begin
                    if (release_hit) state_nxt = ARB_IDLE;
                end
                default: state_nxt = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        fence      = (state == ARB_FENCE);
        fence_busy = fence;
    end

    // Bundle only changes on accept, which load_ok forbids while valid and unconsumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_vld    <= 1'b0;
            alu_bundle <= '0;
            ptr        <= '0;
        end else if (flush) begin
            alu_vld <= 1'b0;
        end else if (accept) begin
            alu_vld    <= 1'b1;
            alu_bundle <= sel_bundle;
            ptr        <= ptr_nxt;
        end else if (consumed) begin
            alu_vld <= 1'b0;
        end
    end

`ifdef TOY_SIM
    release_only_in_fence: assert property (
        @(posedge clk) disable iff (!rst_n) alu_pc_release_en |-> (state == ARB_FENCE)
    );
`endif

endmodule
